// File: rtl/message_padder.sv
// Byte-message padder: fills a 16x32 block, appends 0x80, zeros and the bit length, then kicks the cruncher.
// Optional build macro MSG_LENGTH_CHECK_EN: flag (err) and drop messages longer than 55 bytes.
module message_padder (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   input  logic        in_last,
   output logic        in_ready,
   input  logic [3:0]  gaddr,
   output logic [31:0] mdata,
   output logic        crunch_reset,
   output logic        crunch_start,
   input  logic        crunch_done,
   output logic        digest_valid,
   output logic        err
);

   localparam int unsigned BYTE_W   = 8;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned DEPTH    = 16;
   localparam int unsigned LEN_W    = 6;
   localparam int unsigned LAST_POS = 55;

   typedef enum logic [2:0] {
      S_FILL,
      S_PAD,
      S_LEN,
      S_KRST,
      S_KSTART,
      S_WAIT
   } state_t;

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    ptr_q, ptr_d;
   logic                in_ready_q, in_ready_d;
   logic                crunch_reset_q, crunch_reset_d;
   logic                crunch_start_q, crunch_start_d;
   logic                digest_valid_q, digest_valid_d;
`ifdef MSG_LENGTH_CHECK_EN
   logic                err_q, err_d;
   logic                drop_q, drop_d;
`endif

   logic [WORD_W-1:0]   mem_q [DEPTH];
   logic                accept_c;
   logic                byte_we_c;
   logic [LEN_W-1:0]    byte_pos_c;
   logic [BYTE_W-1:0]   byte_val_c;
   logic                len_we_c;

   assign accept_c = in_valid && in_ready_q;

   // Next-state, write-port and output decode
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      ptr_d          = ptr_q;
      byte_we_c      = 1'b0;
      byte_pos_c     = len_q;
      byte_val_c     = in_data;
      len_we_c       = 1'b0;
`ifdef MSG_LENGTH_CHECK_EN
      err_d          = err_q;
      drop_d         = drop_q;
`endif

      case (state_q)
         S_FILL: begin
            if (accept_c) begin
`ifdef MSG_LENGTH_CHECK_EN
               if (drop_q) begin
                  if (in_last) begin
                     drop_d = 1'b0;
                  end
               end else if (len_q == LEN_W'(LAST_POS)) begin
                  // 56th byte: poison the message and swallow the rest of it
                  err_d  = 1'b1;
                  drop_d = !in_last;
                  len_d  = '0;
               end else begin
                  byte_we_c = 1'b1;
                  len_d     = len_q + LEN_W'(1);
                  if (in_last) begin
                     state_d = S_PAD;
                     ptr_d   = len_q + LEN_W'(1);
                  end
               end
`else
               // Bytes past position 54 are accepted but dropped; len saturates at 55
               if (len_q < LEN_W'(LAST_POS)) begin
                  byte_we_c = 1'b1;
                  len_d     = len_q + LEN_W'(1);
               end
               if (in_last) begin
                  state_d = S_PAD;
                  ptr_d   = len_d;
               end
`endif
            end
         end

         S_PAD: begin
            byte_we_c  = 1'b1;
            byte_pos_c = ptr_q;
            byte_val_c = (ptr_q == len_q) ? BYTE_W'(8'h80) : BYTE_W'(8'h00);
            if (ptr_q == LEN_W'(LAST_POS)) begin
               state_d = S_LEN;
            end else begin
               ptr_d = ptr_q + LEN_W'(1);
            end
         end

         S_LEN: begin
            len_we_c = 1'b1;
            state_d  = S_KRST;
         end

         S_KRST: begin
            state_d = S_KSTART;
         end

         S_KSTART: begin
            state_d = S_WAIT;
         end

         S_WAIT: begin
            if (crunch_done) begin
               len_d   = '0;
               state_d = S_FILL;
            end
         end

         default: begin
            state_d = S_FILL;
         end
      endcase

      in_ready_d     = (state_d == S_FILL);
      crunch_reset_d = (state_d == S_KRST);
      crunch_start_d = (state_d == S_KSTART);
      digest_valid_d = (state_q == S_WAIT) && crunch_done;
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_FILL;
         len_q          <= '0;
         ptr_q          <= '0;
         in_ready_q     <= 1'b1;
         crunch_reset_q <= 1'b0;
         crunch_start_q <= 1'b0;
         digest_valid_q <= 1'b0;
`ifdef MSG_LENGTH_CHECK_EN
         err_q          <= 1'b0;
         drop_q         <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         ptr_q          <= ptr_d;
         in_ready_q     <= in_ready_d;
         crunch_reset_q <= crunch_reset_d;
         crunch_start_q <= crunch_start_d;
         digest_valid_q <= digest_valid_d;
`ifdef MSG_LENGTH_CHECK_EN
         err_q          <= err_d;
         drop_q         <= drop_d;
`endif
      end
   end

   // Block buffer: byte lane writes, plus the two length words in one cycle
   always_ff @(posedge clk) begin
      if (byte_we_c) begin
         mem_q[byte_pos_c[5:2]][{byte_pos_c[1:0], 3'b000} +: BYTE_W] <= byte_val_c;
      end
      if (len_we_c) begin
         mem_q[14] <= WORD_W'({len_q, 3'b000});
         mem_q[15] <= '0;
      end
   end

   assign mdata        = mem_q[gaddr];
   assign in_ready     = in_ready_q;
   assign crunch_reset = crunch_reset_q;
   assign crunch_start = crunch_start_q;
   assign digest_valid = digest_valid_q;
`ifdef MSG_LENGTH_CHECK_EN
   assign err          = err_q;
`else
   assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_message_padder.sv
// Scoreboard bench for message_padder: random messages, reference padding model, cruncher handshake.
`timescale 1ns/10ps
module tb_message_padder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [3:0]  gaddr = '0;
   logic [31:0] mdata;
   logic        crunch_reset;
   logic        crunch_start;
   logic        crunch_done = 1'b0;
   logic        digest_valid;
   logic        err;

   message_padder dut (
      .clk          (clk),
      .reset        (reset),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_ready     (in_ready),
      .gaddr        (gaddr),
      .mdata        (mdata),
      .crunch_reset (crunch_reset),
      .crunch_start (crunch_start),
      .crunch_done  (crunch_done),
      .digest_valid (digest_valid),
      .err          (err)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0][31:0] w;
      int unsigned       start_cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] msg [64];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Padded block as the message rules define it: data, 0x80, zeros to byte 55, bit length, zero word
   function automatic logic [15:0][31:0] ref_words(input int len);
      logic [7:0]        b [64];
      logic [15:0][31:0] w;
      int                le;
      le = (len > 55) ? 55 : len;
      for (int i = 0; i < 64; i++) begin
         if (i < le)       b[i] = msg[i];
         else if (i == le) b[i] = 8'h80;
         else              b[i] = 8'h00;
      end
      for (int k = 0; k < 14; k++) w[k] = {b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]};
      w[14] = 32'(le * 8);
      w[15] = 32'd0;
      return w;
   endfunction

   task automatic check_buf(input logic [15:0][31:0] w, input string name);
      for (int k = 0; k < 16; k++) begin
         gaddr = 4'(k);
         #0.25;
         chk($sformatf("%s_w%0d", name, k), mdata, w[k]);
      end
   endtask

   // Monitor: pops an expected block at each crunch_start and checks timing, buffer and digest handshake
   initial begin : monitor
      exp_t        cur;
      logic        active;
      logic        dig_pending;
      logic        prev_cr;
      int unsigned dig_cyc;
      active = 1'b0; dig_pending = 1'b0; prev_cr = 1'b0; dig_cyc = 0; cur = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            active      = 1'b0;
            dig_pending = 1'b0;
            prev_cr     = 1'b0;
         end else begin
            if (exp_q.size() != 0 || (active && !(dig_pending && cyc == dig_cyc)))
               chk("in_ready_busy", 32'(in_ready), 32'd0);
            if (crunch_start) begin
               chk("crunch_reset_lead", 32'(prev_cr), 32'd1);
               chk("crunch_reset_width", 32'(crunch_reset), 32'd0);
               if (exp_q.size() == 0) begin
                  fail("unexpected_crunch_start");
               end else begin
                  cur = exp_q.pop_front();
                  chk("start_latency", cyc, cur.start_cyc);
                  check_buf(cur.w, "buf_at_start");
                  active = 1'b1;
               end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].start_cyc) begin
               fail("missing_crunch_start");
               void'(exp_q.pop_front());
            end
            if (dig_pending && cyc == dig_cyc) begin
               chk("digest_valid", 32'(digest_valid), 32'd1);
               chk("in_ready_after_digest", 32'(in_ready), 32'd1);
               check_buf(cur.w, "buf_at_digest");
               active      = 1'b0;
               dig_pending = 1'b0;
            end else if (digest_valid) begin
               fail("unexpected_digest_valid");
            end else if (active && !dig_pending && crunch_done) begin
               dig_pending = 1'b1;
               dig_cyc     = cyc + 1;
            end
            prev_cr = crunch_reset;
         end
      end
   end

   task automatic send_byte(input logic [7:0] d, input logic last, output int unsigned acc);
      int n;
      if ($urandom_range(0, 3) == 0) begin
         in_valid = 1'b0;
         tick();
      end
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      if (!in_ready) fail("accept_timeout");
      acc = cyc;
      tick();
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      crunch_done = 1'b0;
      exp_q.delete();
      tick();
      reset = 1'b0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_crunch_reset", 32'(crunch_reset), 32'd0);
      chk("rst_crunch_start", 32'(crunch_start), 32'd0);
      chk("rst_digest_valid", 32'(digest_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
   endtask

   // mode 0: full cruncher handshake; 1: reset in PAD; 2: reset in WAIT
   task automatic run_msg(input int len, input int mode);
      int unsigned acc;
      int          le;
      int          n;
      logic        expect_start;
      exp_t        e;
      le = (len > 55) ? 55 : len;
`ifdef MSG_LENGTH_CHECK_EN
      expect_start = (len <= 55);
`else
      expect_start = 1'b1;
`endif
      acc = 0;
      for (int i = 0; i < len; i++) send_byte(msg[i], (i == len - 1), acc);
      if (!expect_start) begin
         in_valid = 1'b0;
         in_last  = 1'b0;
         chk("err_oversize", 32'(err), 32'd1);
         chk("in_ready_after_drop", 32'(in_ready), 32'd1);
         repeat (80) tick();
         return;
      end
      if (mode != 1) begin
         e.w         = ref_words(len);
         e.start_cyc = acc + 32'(59 - le);
         exp_q.push_back(e);
      end
      in_valid = 1'b1;
      in_last  = 1'($urandom);
      in_data  = 8'($urandom);
      if (mode == 1) begin
         repeat (5) tick();
         do_reset();
         repeat (70) tick();
         return;
      end
      n = 0;
      while (!crunch_start && n < 200) begin
         if (crunch_reset) crunch_done = 1'b0;
         in_data = 8'($urandom);
         in_last = 1'($urandom);
         tick();
         n++;
      end
      if (!crunch_start) begin
         fail("start_timeout");
         in_valid = 1'b0;
         return;
      end
      if (mode == 2) begin
         repeat (3) tick();
         do_reset();
         repeat (30) tick();
         return;
      end
      repeat (10) tick();
      in_valid    = 1'b0;
      in_last     = 1'b0;
      crunch_done = 1'b1;
      tick();
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (!in_ready) fail("return_to_fill_timeout");
      repeat ($urandom_range(0, 3)) tick();
   endtask

   task automatic load_abc();
      msg[0] = 8'h61;
      msg[1] = 8'h62;
      msg[2] = 8'h63;
   endtask

   task automatic load_random(input int len);
      for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
   endtask

   initial begin : driver
      reset = 1'b1;
      repeat (3) tick();
      chk("init_in_ready", 32'(in_ready), 32'd1);
      chk("init_crunch_reset", 32'(crunch_reset), 32'd0);
      chk("init_crunch_start", 32'(crunch_start), 32'd0);
      chk("init_digest_valid", 32'(digest_valid), 32'd0);
      chk("init_err", 32'(err), 32'd0);
      reset = 1'b0;
      tick();

      load_abc();
      run_msg(3, 0);
      load_random(55);
      run_msg(55, 0);
      for (int t = 0; t < 8; t++) begin
         int len;
         len = $urandom_range(1, 55);
         load_random(len);
         run_msg(len, 0);
      end
      load_random(60);
      run_msg(60, 0);
      load_abc();
      run_msg(3, 0);

      load_random(10);
      run_msg(10, 1);
      load_abc();
      run_msg(3, 0);

      load_random(20);
      run_msg(20, 2);
      load_abc();
      run_msg(3, 0);

      repeat (5) tick();
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
